// File: rtl/div.sv
// div: multi-cycle restoring 32-bit divider for DIV/DIVU.
// One trial subtraction per cycle; result held until start_i drops.
module div (
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);
   typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_e;
   state_e      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [64:0] dividend_q, dividend_d;
   logic [31:0] divisor_q, divisor_d;
   logic        sdiv_q, sdiv_d, s1_q, s1_d, s2_q, s2_d;
   logic [63:0] result_q, result_d;
   logic        ready_q, ready_d;
   logic [32:0] diff;
   logic [31:0] op1_abs, op2_abs, q_fix, r_fix;
   assign diff    = {1'b0, dividend_q[63:32]} - {1'b0, divisor_q};
   assign op1_abs = (signed_div_i & opdata1_i[31]) ? -opdata1_i : opdata1_i;
   assign op2_abs = (signed_div_i & opdata2_i[31]) ? -opdata2_i : opdata2_i;
   assign q_fix   = (sdiv_q & (s1_q ^ s2_q)) ? -dividend_q[31:0] : dividend_q[31:0];
   assign r_fix   = (sdiv_q & s1_q) ? -dividend_q[64:33] : dividend_q[64:33];
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      sdiv_d     = sdiv_q;
      s1_d       = s1_q;
      s2_d       = s2_q;
      result_d   = result_q;
      ready_d    = ready_q;
      case (state_q)
         S_FREE: if (start_i && !annul_i) begin
            state_d    = (opdata2_i == 32'd0) ? S_BYZERO : S_ON;
            cnt_d      = 6'd0;
            dividend_d = {32'd0, op1_abs, 1'b0};
            divisor_d  = op2_abs;
            sdiv_d     = signed_div_i;
            s1_d       = opdata1_i[31];
            s2_d       = opdata2_i[31];
         end
         // divide-by-zero dwells two cycles so ready_o rises after edge 2
         S_BYZERO: if (annul_i) state_d = S_FREE;
         else if (cnt_q == 6'd0) cnt_d = 6'd1;
         else begin
            state_d  = S_END;
            result_d = 64'd0;
            ready_d  = 1'b1;
         end
         S_ON: if (annul_i) state_d = S_FREE;
         else if (cnt_q != 6'd32) begin
            dividend_d = diff[32] ? dividend_q << 1 : {diff[31:0], dividend_q[31:0], 1'b1};
            cnt_d      = cnt_q + 6'd1;
         end else begin
            state_d  = S_END;
            result_d = {r_fix, q_fix};
            ready_d  = 1'b1;
         end
         default: if (!start_i) begin
            state_d  = S_FREE;
            result_d = 64'd0;
            ready_d  = 1'b0;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_FREE;
         cnt_q      <= 6'd0;
         dividend_q <= 65'd0;
         divisor_q  <= 32'd0;
         sdiv_q     <= 1'b0;
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         result_q   <= 64'd0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         sdiv_q     <= sdiv_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         result_q   <= result_d;
         ready_q    <= ready_d;
      end
   end
   assign result_o = result_q;
   assign ready_o  = ready_q;
endmodule

// File: tb/tb_div.sv
// tb_div: randomized self-checking bench for div against a plain-arithmetic model.
module tb_div;
   logic        clk = 1'b0, rst = 1'b1, signed_div_i = 1'b0, start_i = 1'b0, annul_i = 1'b0;
   logic [31:0] opdata1_i = '0, opdata2_i = '0;
   logic [63:0] result_o;
   logic        ready_o;
   int          errors = 0, checks = 0;
   div dut (
      .clk(clk), .rst(rst), .signed_div_i(signed_div_i), .opdata1_i(opdata1_i),
      .opdata2_i(opdata2_i), .start_i(start_i), .annul_i(annul_i),
      .result_o(result_o), .ready_o(ready_o)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'd0;
      sa = s ? longint'($signed(a)) : longint'(a);
      sb = s ? longint'($signed(b)) : longint'(b);
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction
   // edges counted from the one that samples start (edge 0); returns edges until ready
   task automatic wait_ready(input bit scramble, output int lat);
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
         if (scramble && n == 1) begin
            opdata1_i = $urandom;
            opdata2_i = $urandom;
            signed_div_i = ~signed_div_i;
         end
      end while (!ready_o && n < 60);
      lat = n - 1;
   endtask
   task automatic finish_op(input logic [63:0] exp);
      @(posedge clk); #1;
      check("hold_ready", {63'd0, ready_o}, 64'd1);
      check("hold_result", result_o, exp);
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk); #1;
      check("drop_ready", {63'd0, ready_o}, 64'd0);
      check("drop_result", result_o, 64'd0);
   endtask
   task automatic run(input bit s, input logic [31:0] a, input logic [31:0] b);
      int lat;
      logic [63:0] exp;
      exp = model(s, a, b);
      @(negedge clk);
      signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
      wait_ready(1'b1, lat);
      check("latency", 64'(lat), (b == 32'd0) ? 64'd2 : 64'd33);
      check("result", result_o, exp);
      finish_op(exp);
   endtask
   initial begin
      int lat, seen;
      logic [31:0] a, b;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", {63'd0, ready_o}, 64'd0);
      check("rst_result", result_o, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      check("model_divu_100_7", model(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
      run(1'b0, 32'd100, 32'd7);
      run(1'b1, 32'hFFFFFFF9, 32'd2);
      run(1'b1, 32'd7, 32'hFFFFFFFE);
      run(1'b1, 32'h80000000, 32'hFFFFFFFF);
      run(1'b0, 32'hFFFFFFFF, 32'd1);
      run(1'b0, 32'd5, 32'd0);
      run(1'b0, 32'd9, 32'd3);
      run(1'b1, 32'h80000000, 32'd0);
      // annul at edge 10 of 1000/3
      @(negedge clk);
      signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (9) @(negedge clk);
      annul_i = 1'b1;
      @(negedge clk);
      annul_i = 1'b0;
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (ready_o) seen++;
      end
      check("annul_no_ready", 64'(seen), 64'd0);
      run(1'b0, 32'd1000, 32'd3);
      // reset at edge 20 with start held throughout
      @(negedge clk);
      signed_div_i = 1'b1; opdata1_i = 32'hFFFFFC18; opdata2_i = 32'd7; start_i = 1'b1;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_ready", {63'd0, ready_o}, 64'd0);
      check("rst_mid_result", result_o, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      wait_ready(1'b0, lat);
      check("rst_restart_lat", 64'(lat), 64'd33);
      check("rst_restart_res", result_o, model(1'b1, 32'hFFFFFC18, 32'd7));
      finish_op(model(1'b1, 32'hFFFFFC18, 32'd7));
      for (int i = 0; i < 30; i++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = 32'($urandom_range(0, 15));
            1: b = -32'($urandom_range(1, 15));
            default: b = $urandom >> $urandom_range(0, 31);
         endcase
         run(1'($urandom_range(0, 1)), a, b);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
